// File: rtl/common.sv
// Types and constants shared across the pipeline stages of the RISC-V core.
package common;

  localparam int unsigned DEFAULT_MEM_ADDRESS_WIDTH = 12;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [6:0] OPCODE_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_store_funct3_t;

  // Stores reuse the load encodings for the same access width.
  localparam load_store_funct3_t SB = LB;
  localparam load_store_funct3_t SH = LH;
  localparam load_store_funct3_t SW = LW;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } decoded_instruction_t;

  typedef struct packed {
    logic [31:0]          program_counter;
    decoded_instruction_t decoded_instruction;
    logic [31:0]          alu_result;
    logic [31:0]          store_data;
  } execute_to_memory_t;

  typedef struct packed {
    logic [31:0]          program_counter;
    decoded_instruction_t decoded_instruction;
    logic [31:0]          result;
    logic                 misaligned;
  } memory_to_writeback_t;

  function automatic logic is_valid_access(input logic [6:0] opcode, input logic [2:0] funct3);
    logic valid;
    valid = 1'b0;
    if (opcode == OPCODE_LOAD) begin
      case (funct3)
        LB, LH, LW, LBU, LHU: valid = 1'b1;
        default:              valid = 1'b0;
      endcase
    end else if (opcode == OPCODE_STORE) begin
      case (funct3)
        SB, SH, SW: valid = 1'b1;
        default:    valid = 1'b0;
      endcase
    end
    return valid;
  endfunction

endpackage

// File: rtl/memory_stage_load_store_align.sv
// Combinational lane steering: store byte enables/data replication and load extraction.
module load_store_align
  import common::*;
(
  input  logic [2:0]  access_funct3,
  input  logic [1:0]  access_offset,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_enable,
  output logic [31:0] write_data,
  output logic        misaligned,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] read_data,
  output logic [31:0] load_result
);

  logic [31:0] shifted;

  always_comb begin
    byte_enable = '0;
    write_data  = '0;
    misaligned  = 1'b0;
    case (access_funct3)
      SB: begin
        byte_enable = 4'b0001 << access_offset;
        write_data  = {4{store_data[7:0]}};
      end
      SH, LHU: begin
        byte_enable = 4'b0011 << access_offset;
        write_data  = {2{store_data[15:0]}};
        misaligned  = access_offset[0];
      end
      SW: begin
        byte_enable = 4'b1111;
        write_data  = store_data;
        misaligned  = |access_offset;
      end
      default: ;
    endcase
  end

  // Bring the addressed byte/half down to lane 0 before extending.
  assign shifted = read_data >> {load_offset, 3'b000};

  always_comb begin
    load_result = '0;
    case (load_funct3)
      LB:      load_result = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     load_result = {24'd0, shifted[7:0]};
      LH:      load_result = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     load_result = {16'd0, shifted[15:0]};
      LW:      load_result = read_data;
      default: load_result = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Fourth pipeline stage: data SRAM loads/stores with a one-deep AXI-Stream output register.
module memory_stage
  import common::*;
#(
  parameter int unsigned MEM_ADDRESS_WIDTH = DEFAULT_MEM_ADDRESS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_tvalid,
  output logic                         in_tready,
  input  execute_to_memory_t           in_tdata,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output memory_to_writeback_t         out_tdata,
  output logic [MEM_ADDRESS_WIDTH-1:0] sram_address,
  output logic                         sram_write_enable,
  output logic [3:0]                   sram_byte_enable,
  output logic [31:0]                  sram_write_data,
  input  logic [31:0]                  sram_read_data
);

  logic [MEM_ADDRESS_WIDTH-1:0] address_q;
  memory_to_writeback_t         out_q;
  logic                         out_tvalid_q;
  logic                         load_q;
  logic                         captured_q;
  logic [1:0]                   offset_q;
  logic [31:0]                  hold_q;

  logic                 in_fire;
  logic [6:0]           in_opcode;
  logic [2:0]           in_funct3;
  logic [1:0]           in_offset;
  logic                 in_is_load;
  logic                 in_is_store;
  logic                 in_is_mem;
  logic                 in_valid_access;
  logic                 access;
  logic [3:0]           store_byte_enable;
  logic [31:0]          store_write_data;
  logic                 access_misaligned;
  logic [31:0]          live_result;
  memory_to_writeback_t in_entry;

  assign in_tready       = !out_tvalid_q || out_tready;
  assign in_fire         = in_tvalid && in_tready;
  assign in_opcode       = in_tdata.decoded_instruction.opcode;
  assign in_funct3       = in_tdata.decoded_instruction.funct3;
  assign in_offset       = in_tdata.alu_result[1:0];
  assign in_is_load      = (in_opcode == OPCODE_LOAD);
  assign in_is_store     = (in_opcode == OPCODE_STORE);
  assign in_is_mem       = in_is_load || in_is_store;
  assign in_valid_access = is_valid_access(in_opcode, in_funct3);
  assign access          = in_fire && in_valid_access && !access_misaligned;

  load_store_align u_align (
    .access_funct3 (in_funct3),
    .access_offset (in_offset),
    .store_data    (in_tdata.store_data),
    .byte_enable   (store_byte_enable),
    .write_data    (store_write_data),
    .misaligned    (access_misaligned),
    .load_funct3   (out_q.decoded_instruction.funct3),
    .load_offset   (offset_q),
    .read_data     (sram_read_data),
    .load_result   (live_result)
  );

  // SRAM port: only touched in an accept cycle; the address parks on its last value otherwise.
  always_comb begin
    sram_address      = address_q;
    sram_write_enable = 1'b0;
    sram_byte_enable  = '0;
    sram_write_data   = '0;
    if (access) begin
      sram_address = in_tdata.alu_result[MEM_ADDRESS_WIDTH+1:2];
      if (in_is_store) begin
        sram_write_enable = 1'b1;
        sram_byte_enable  = store_byte_enable;
        sram_write_data   = store_write_data;
      end else begin
        sram_byte_enable = 4'b1111;
      end
    end
  end

  always_comb begin
    in_entry.program_counter     = in_tdata.program_counter;
    in_entry.decoded_instruction = in_tdata.decoded_instruction;
    in_entry.result              = in_is_mem ? 32'd0 : in_tdata.alu_result;
    in_entry.misaligned          = in_valid_access && access_misaligned;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address_q    <= '0;
      out_q        <= '0;
      out_tvalid_q <= 1'b0;
      load_q       <= 1'b0;
      captured_q   <= 1'b0;
      offset_q     <= '0;
      hold_q       <= '0;
    end else begin
      if (access) begin
        address_q <= in_tdata.alu_result[MEM_ADDRESS_WIDTH+1:2];
      end
      if (in_fire) begin
        out_q        <= in_entry;
        out_tvalid_q <= 1'b1;
        load_q       <= access && in_is_load;
        offset_q     <= in_offset;
        captured_q   <= 1'b0;
      end else if (out_tvalid_q && out_tready) begin
        out_tvalid_q <= 1'b0;
        load_q       <= 1'b0;
        captured_q   <= 1'b0;
      end else if (load_q && !captured_q) begin
        // read_data is only valid for one cycle; keep it for the rest of the stall.
        hold_q     <= live_result;
        captured_q <= 1'b1;
      end
    end
  end

  assign out_tvalid = out_tvalid_q;

  always_comb begin
    out_tdata = out_q;
    if (load_q) begin
      out_tdata.result = captured_q ? hold_q : live_result;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised and directed bench for memory_stage against a word-array reference model.
module tb_memory_stage;
  import common::*;

  localparam int unsigned W     = DEFAULT_MEM_ADDRESS_WIDTH;
  localparam int unsigned DEPTH = 1 << W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_tvalid;
  logic                 in_tready;
  execute_to_memory_t   in_tdata;
  logic                 out_tvalid;
  logic                 out_tready;
  memory_to_writeback_t out_tdata;
  logic [W-1:0]         sram_address;
  logic                 sram_write_enable;
  logic [3:0]           sram_byte_enable;
  logic [31:0]          sram_write_data;
  logic [31:0]          sram_read_data;

  always #5 clk = ~clk;

  memory_stage #(.MEM_ADDRESS_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_tvalid         (in_tvalid),
    .in_tready         (in_tready),
    .in_tdata          (in_tdata),
    .out_tvalid        (out_tvalid),
    .out_tready        (out_tready),
    .out_tdata         (out_tdata),
    .sram_address      (sram_address),
    .sram_write_enable (sram_write_enable),
    .sram_byte_enable  (sram_byte_enable),
    .sram_write_data   (sram_write_data),
    .sram_read_data    (sram_read_data)
  );

  logic [31:0] sram_mem [DEPTH];
  logic [31:0] ref_mem  [DEPTH];

  // SRAM environment: read data valid one cycle after address, garbage when not reading.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= ref_mem[i];
    end
    if (sram_write_enable) begin
      for (int k = 0; k < 4; k++)
        if (sram_byte_enable[k]) sram_mem[sram_address][8*k +: 8] <= sram_write_data[8*k +: 8];
    end
    if (sram_byte_enable != 4'b0000 && !sram_write_enable) sram_read_data <= sram_mem[sram_address];
    else sram_read_data <= $urandom;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned access_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_valid(input logic [6:0] op, input logic [2:0] f3);
    if (op == 7'b0000011) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    if (op == 7'b0100011) return f3 <= 3'd2;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int unsigned off,
                                             input logic [31:0] word);
    int unsigned size;
    logic [31:0] v, mask;
    size = access_size(f3);
    v    = word >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v    = v & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_replicate(input int unsigned size, input logic [31:0] sd);
    if (size == 1) return {4{sd[7:0]}};
    if (size == 2) return {2{sd[15:0]}};
    return sd;
  endfunction

  // Reference model: one step per cycle, sampled at the falling edge.
  logic                 m_valid = 1'b0;
  memory_to_writeback_t m_data  = '0;
  logic [W-1:0]         m_addr  = '0;

  always @(negedge clk) begin : model
    execute_to_memory_t   d;
    memory_to_writeback_t e;
    logic                 acc, mem_op, valid, mis, exp_ready, exp_we;
    logic [3:0]           exp_be;
    logic [W-1:0]         exp_addr;
    int unsigned          size, off;
    if (!rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_addr  = '0;
    end else begin
      d         = in_tdata;
      mem_op    = d.decoded_instruction.opcode == 7'b0000011 ||
                  d.decoded_instruction.opcode == 7'b0100011;
      valid     = model_valid(d.decoded_instruction.opcode, d.decoded_instruction.funct3);
      size      = access_size(d.decoded_instruction.funct3);
      off       = int'(d.alu_result[1:0]);
      mis       = valid && (off % size != 0);
      exp_ready = !m_valid || out_tready;
      acc       = in_tvalid && exp_ready;
      check("in_tready", in_tready, exp_ready);
      check("out_tvalid", out_tvalid, m_valid);
      if (m_valid) check("out_tdata", out_tdata, m_data);
      exp_we   = 1'b0;
      exp_be   = 4'b0000;
      exp_addr = m_addr;
      if (acc && valid && !mis) begin
        exp_addr = d.alu_result[W+1:2];
        if (d.decoded_instruction.opcode == 7'b0100011) begin
          exp_we = 1'b1;
          exp_be = 4'(((1 << size) - 1) << off);
        end else begin
          exp_be = 4'b1111;
        end
      end
      check("sram_address", sram_address, exp_addr);
      check("sram_write_enable", sram_write_enable, exp_we);
      check("sram_byte_enable", sram_byte_enable, exp_be);
      if (exp_we) check("sram_write_data", sram_write_data, model_replicate(size, d.store_data));
      if (acc) begin
        e.program_counter     = d.program_counter;
        e.decoded_instruction = d.decoded_instruction;
        e.misaligned          = mis;
        e.result              = mem_op ? 32'd0 : d.alu_result;
        if (valid && !mis) begin
          m_addr = exp_addr;
          if (exp_we) begin
            for (int k = 0; k < size; k++)
              ref_mem[exp_addr][8*(off+k) +: 8] = d.store_data[8*k +: 8];
          end else begin
            e.result = model_load(d.decoded_instruction.funct3, off, ref_mem[exp_addr]);
          end
        end
        m_data  = e;
        m_valid = 1'b1;
      end else if (m_valid && out_tready) begin
        m_valid = 1'b0;
      end
    end
  end

  function automatic execute_to_memory_t make_instr(input logic [6:0] op, input logic [2:0] f3,
                                                    input logic [31:0] addr, input logic [31:0] sd);
    execute_to_memory_t t;
    t.program_counter                 = $urandom;
    t.decoded_instruction.opcode      = op;
    t.decoded_instruction.rd          = 5'($urandom);
    t.decoded_instruction.funct3      = f3;
    t.decoded_instruction.rs1         = 5'($urandom);
    t.decoded_instruction.rs2         = 5'($urandom);
    t.alu_result                      = addr;
    t.store_data                      = sd;
    return t;
  endfunction

  function automatic execute_to_memory_t rand_instr();
    int unsigned r;
    logic [2:0]  f3;
    logic [31:0] addr;
    r    = $urandom % 5;
    addr = 32'h400 + (($urandom % 16) << 2) + ($urandom % 4);
    if (r < 2) begin
      case ($urandom % 5)
        0:       f3 = 3'd0;
        1:       f3 = 3'd1;
        2:       f3 = 3'd2;
        3:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
      return make_instr(OPCODE_LOAD, f3, addr, $urandom);
    end
    if (r < 4) return make_instr(OPCODE_STORE, 3'($urandom % 3), addr, $urandom);
    return make_instr(OPCODE_OP, 3'($urandom), $urandom, $urandom);
  endfunction

  logic         rec_we;
  logic [3:0]   rec_be;
  logic [W-1:0] rec_addr;
  logic [31:0]  rec_wd;

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd);
    logic acc;
    int   n;
    in_tdata  = make_instr(op, f3, addr, sd);
    in_tvalid = 1'b1;
    n         = 0;
    do begin
      @(negedge clk);
      acc      = in_tready;
      rec_we   = sram_write_enable;
      rec_be   = sram_byte_enable;
      rec_addr = sram_address;
      rec_wd   = sram_write_data;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    if (!acc) check("accept_timeout", 1'b0, 1'b1);
    in_tvalid = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [31:0] exp, input logic exp_mis);
    @(negedge clk);
    check({name, "_valid"}, out_tvalid, 1'b1);
    check(name, out_tdata.result, exp);
    check({name, "_misaligned"}, out_tdata.misaligned, exp_mis);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    logic        last_acc;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    out_tready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      v          = $urandom;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_out_tvalid", out_tvalid, 1'b0);
    check("reset_out_tdata", out_tdata, '0);
    check("reset_sram_address", sram_address, '0);
    @(posedge clk);
    #1;

    // Word round trip, back to back.
    issue(OPCODE_STORE, SW, 32'h100, 32'hDEAD_BEEF);
    check("sw_byte_enable", rec_be, 4'b1111);
    check("sw_address", rec_addr, 32'h40);
    check("sw_write_enable", rec_we, 1'b1);
    issue(OPCODE_LOAD, LW, 32'h100, 32'h0);
    check_now("lw_roundtrip", 32'hDEAD_BEEF, 1'b0);

    // Byte and half extraction.
    issue(OPCODE_STORE, SW, 32'h200, 32'h80F0_7F81);
    issue(OPCODE_LOAD, LB, 32'h200, 32'h0);
    check_now("lb_200", 32'hFFFF_FF81, 1'b0);
    issue(OPCODE_LOAD, LBU, 32'h203, 32'h0);
    check_now("lbu_203", 32'h0000_0080, 1'b0);
    issue(OPCODE_LOAD, LH, 32'h202, 32'h0);
    check_now("lh_202", 32'hFFFF_80F0, 1'b0);
    issue(OPCODE_LOAD, LHU, 32'h200, 32'h0);
    check_now("lhu_200", 32'h0000_7F81, 1'b0);

    // Sub-word store merges into the existing word.
    issue(OPCODE_STORE, SW, 32'h304, 32'h1122_3344);
    issue(OPCODE_STORE, SB, 32'h305, 32'h0000_00AB);
    check("sb_byte_enable", rec_be, 4'b0010);
    check("sb_write_data", rec_wd, 32'hABAB_ABAB);
    issue(OPCODE_LOAD, LW, 32'h304, 32'h0);
    check_now("lw_after_sb", 32'h1122_AB44, 1'b0);

    // Load held across a long stall while read_data is scrambled.
    out_tready = 1'b0;
    issue(OPCODE_LOAD, LW, 32'h100, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_tready", in_tready, 1'b0);
      check("stall_result", out_tdata.result, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
    end
    out_tready = 1'b1;
    check_now("stall_release", 32'hDEAD_BEEF, 1'b0);

    // Misaligned accesses make no SRAM access.
    issue(OPCODE_LOAD, LW, 32'h102, 32'h0);
    check("mis_lw_write_enable", rec_we, 1'b0);
    check("mis_lw_byte_enable", rec_be, 4'b0000);
    check_now("mis_lw", 32'h0, 1'b1);
    issue(OPCODE_STORE, SH, 32'h101, 32'h5555_5555);
    check("mis_sh_write_enable", rec_we, 1'b0);
    check_now("mis_sh", 32'h0, 1'b1);

    // Asynchronous reset drops an in-flight output.
    out_tready = 1'b0;
    issue(OPCODE_LOAD, LW, 32'h200, 32'h0);
    #2 rst = 1'b0;
    #1 check("async_reset_drop", out_tvalid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_tready = 1'b1;
    @(negedge clk);
    check("post_reset_out_tvalid", out_tvalid, 1'b0);
    check("post_reset_sram_address", sram_address, '0);
    @(posedge clk);
    #1;
    issue(OPCODE_LOAD, LW, 32'h100, 32'h0);
    check_now("post_reset_lw", 32'hDEAD_BEEF, 1'b0);

    // Randomised traffic with random backpressure; the model checks every cycle.
    last_acc = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!in_tvalid || last_acc) begin
        in_tvalid = ($urandom % 4) != 0;
        in_tdata  = rand_instr();
      end
      out_tready = ($urandom % 3) != 0;
      @(negedge clk);
      last_acc = in_tvalid && in_tready;
      @(posedge clk);
      #1;
    end
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
